fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares one synchronous FIFO write port between NUM_REQ producers.
- Grants one requester at a time for a bounded burst of up to MAX_BURST words.
- Drives the FIFO wr_en/data_in, honours full, and checks wr_ack/overflow one cycle after each write.
- Sits directly in front of the FIFO instance. The bench binds to its ports and its FIFO-facing side.

---
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port between NUM_REQ producers.
// Grants bounded bursts and flags missing write acknowledges or overflows.
module fifo_wr_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  input  logic                          fifo_full,
  input  logic                          fifo_wr_ack,
  input  logic                          fifo_overflow,
  output logic [NUM_REQ-1:0]            grant,
  output logic                          busy,
  output logic                          err_ack
);

  localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CntW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     owner_q, owner_d;
  logic [IdxW-1:0]     last_owner_q, last_owner_d;
  logic [CntW-1:0]     burst_cnt_q, burst_cnt_d;
  logic                wr_pend_q, wr_pend_d;
  logic                err_ack_q, err_ack_d;
  logic [IdxW-1:0]     winner;
  logic                found;
  logic                wr;
  logic                burst_done;

  // Scan starts just after the last owner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[IdxW'((32'(last_owner_q) + k) % NUM_REQ)]) begin
        found  = 1'b1;
        winner = IdxW'((32'(last_owner_q) + k) % NUM_REQ);
      end
    end
  end

  assign wr         = (state_q == StGrant) && req_valid[owner_q] && !fifo_full && !rst;
  assign burst_done = (burst_cnt_q == CntW'(MAX_BURST - 1));

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d     = StGrant;
          grant_d     = NUM_REQ'(1) << winner;
          owner_d     = winner;
          burst_cnt_d = '0;
        end
      end
      StGrant: begin
        if (wr) begin
          burst_cnt_d = burst_cnt_q + CntW'(1);
        end
        if ((wr && burst_done) || !req_valid[owner_q]) begin
          state_d      = StIdle;
          grant_d      = '0;
          last_owner_d = owner_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // The arbiter never writes while full, so any overflow is an error.
  always_comb begin
    wr_pend_d = wr;
    err_ack_d = err_ack_q | (wr_pend_q & ~fifo_wr_ack) | fifo_overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IdxW'(NUM_REQ - 1);
      burst_cnt_q  <= '0;
      wr_pend_q    <= 1'b0;
      err_ack_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      wr_pend_q    <= wr_pend_d;
      err_ack_q    <= err_ack_d;
    end
  end

  always_comb begin
    req_ready    = wr ? (NUM_REQ'(1) << owner_q) : '0;
    fifo_wr_en   = wr;
    fifo_data_in = (state_q == StGrant) ? req_data[owner_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  end

  assign grant   = grant_q;
  assign busy    = (state_q == StGrant);
  assign err_ack = err_ack_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: per-cycle vector table for control outputs plus a
// scoreboard of expected FIFO words checked whenever the arbiter writes.
module tb_fifo_wr_arbiter;

  localparam int NR = 4;
  localparam int DW = 16;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic [NR-1:0]    req_ready;
  logic             fifo_wr_en;
  logic [DW-1:0]    fifo_data_in;
  logic             fifo_full = 1'b0;
  logic             fifo_wr_ack;
  logic             fifo_overflow = 1'b0;
  logic [NR-1:0]    grant;
  logic             busy;
  logic             err_ack;
  logic             ack_q = 1'b0;
  logic             force_noack = 1'b0;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_WIDTH(DW),
    .MAX_BURST (MB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_data_in (fifo_data_in),
    .fifo_full    (fifo_full),
    .fifo_wr_ack  (fifo_wr_ack),
    .fifo_overflow(fifo_overflow),
    .grant        (grant),
    .busy         (busy),
    .err_ack      (err_ack)
  );

  always #5 clk = ~clk;

  // FIFO model: acknowledges every write one cycle later unless the bench suppresses it.
  always @(posedge clk) ack_q <= fifo_wr_en;
  assign fifo_wr_ack = ack_q && !force_noack;

  typedef struct {
    logic          rst;
    logic [NR-1:0] valid;
    logic          full;
    logic          noack;
    logic          ovf;
    logic [NR-1:0] grant;
    logic          wr;
    logic          err;
  } vec_t;

  vec_t          vecs[$];
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  int            cnt[NR];
  int            exp_cnt[NR];

  function automatic logic [DW-1:0] word(input int i, input int c);
    return DW'(16'h0A00 + i * 256 + c);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic addx(input int n, input logic r, input logic [NR-1:0] v, input logic f,
                      input logic na, input logic ov, input logic [NR-1:0] g, input logic w,
                      input logic e);
    vec_t t;
    t.rst = r; t.valid = v; t.full = f; t.noack = na; t.ovf = ov;
    t.grant = g; t.wr = w; t.err = e;
    for (int i = 0; i < n; i++) vecs.push_back(t);
  endtask

  task automatic add(input int n, input logic [NR-1:0] v, input logic [NR-1:0] g,
                     input logic w, input logic e);
    addx(n, 1'b0, v, 1'b0, 1'b0, 1'b0, g, w, e);
  endtask

  task automatic drive_data();
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = word(i, cnt[i]);
  endtask

  always @(negedge clk) begin
    if (fifo_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_write: got data 0x%0h expected no write", fifo_data_in);
      end else begin
        check("fifo_data", fifo_data_in, exp_q.pop_front());
      end
    end
  end

  initial begin
    int owner;
    for (int i = 0; i < NR; i++) begin
      cnt[i] = 0;
      exp_cnt[i] = 0;
    end
    req_valid = '1;
    drive_data();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err_ack, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_ready", req_ready, 0);

    // Single requester: 4-word bursts, 1-cycle bubble, re-grant.
    add(1, 4'b0001, 4'b0000, 0, 0);
    add(4, 4'b0001, 4'b0001, 1, 0);
    add(1, 4'b0001, 4'b0000, 0, 0);
    add(4, 4'b0001, 4'b0001, 1, 0);
    add(1, 4'b0000, 4'b0000, 0, 0);
    addx(1, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 0);
    // All requesting: strict rotation from requester 0.
    add(1, 4'b1111, 4'b0000, 0, 0);
    for (int g = 0; g < NR; g++) begin
      add(4, 4'b1111, 4'(1 << g), 1, 0);
      add(1, 4'b1111, 4'b0000, 0, 0);
    end
    add(1, 4'b1111, 4'b0001, 1, 0);
    add(1, 4'b0000, 4'b0001, 0, 0);
    add(1, 4'b0000, 4'b0000, 0, 0);
    // Requester 2 stalled by full for 3 cycles after its 2nd word.
    add(1, 4'b0100, 4'b0000, 0, 0);
    add(2, 4'b0100, 4'b0100, 1, 0);
    addx(3, 0, 4'b0100, 1, 0, 0, 4'b0100, 0, 0);
    add(2, 4'b0100, 4'b0100, 1, 0);
    add(1, 4'b0000, 4'b0000, 0, 0);
    // Requester 1 drops after 2 words; requester 3 follows, then rst mid-burst.
    add(1, 4'b0010, 4'b0000, 0, 0);
    add(2, 4'b1010, 4'b0010, 1, 0);
    add(1, 4'b1000, 4'b0010, 0, 0);
    add(1, 4'b1000, 4'b0000, 0, 0);
    add(2, 4'b1000, 4'b1000, 1, 0);
    addx(1, 1, 4'b1000, 0, 0, 0, 4'b1000, 0, 0);
    add(1, 4'b1111, 4'b0000, 0, 0);
    add(4, 4'b1111, 4'b0001, 1, 0);
    add(1, 4'b0000, 4'b0000, 0, 0);
    // Missing ack, then overflow, each sticky until rst.
    add(1, 4'b0001, 4'b0000, 0, 0);
    add(1, 4'b0001, 4'b0001, 1, 0);
    addx(1, 0, 4'b0000, 0, 1, 0, 4'b0001, 0, 0);
    add(2, 4'b0000, 4'b0000, 0, 1);
    addx(1, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 1);
    add(1, 4'b0000, 4'b0000, 0, 0);
    addx(1, 0, 4'b0000, 0, 0, 1, 4'b0000, 0, 0);
    add(2, 4'b0000, 4'b0000, 0, 1);
    addx(1, 1, 4'b0000, 0, 0, 0, 4'b0000, 0, 1);
    add(1, 4'b0000, 4'b0000, 0, 0);

    foreach (vecs[n]) begin
      @(posedge clk);
      #1;
      rst           = vecs[n].rst;
      req_valid     = vecs[n].valid;
      fifo_full     = vecs[n].full;
      force_noack   = vecs[n].noack;
      fifo_overflow = vecs[n].ovf;
      drive_data();
      if (vecs[n].wr) begin
        owner = 0;
        for (int i = 0; i < NR; i++) if (vecs[n].grant[i]) owner = i;
        exp_q.push_back(word(owner, exp_cnt[owner]));
        exp_cnt[owner]++;
      end
      @(negedge clk);
      check($sformatf("grant[%0d]", n), grant, vecs[n].grant);
      check($sformatf("wr_en[%0d]", n), fifo_wr_en, vecs[n].wr);
      check($sformatf("busy[%0d]", n), busy, |vecs[n].grant);
      check($sformatf("err_ack[%0d]", n), err_ack, vecs[n].err);
      check($sformatf("req_ready[%0d]", n), req_ready, vecs[n].wr ? vecs[n].grant : 4'b0000);
      if (vecs[n].grant == 0) check($sformatf("idle_data[%0d]", n), fifo_data_in, 0);
      for (int i = 0; i < NR; i++) if (req_ready[i] === 1'b1) cnt[i]++;
    end

    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
